// File: rtl/rca_seq_ctrl_pkg.sv
// rca_seq_ctrl_pkg: shared constants for the nibble-serial adder (slice width, FSM encodings).
// Build option: define SUB_EN to add the op_sub port and subtract mode.
package rca_seq_ctrl_pkg;
    localparam int NIB_W = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/rca_seq_ctrl_if.sv
// rca_seq_ctrl_if: operand/result valid-ready bus of the nibble-serial adder.
// Signals: in_valid/in_ready/a/b/cin (+op_sub when SUB_EN), out_valid/out_ready/sum/cout.
// master = operand source / result consumer, slave = the adder.
interface rca_seq_ctrl_if
    import rca_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIB_W * NIBBLES;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
`ifdef SUB_EN
        output op_sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
`ifdef SUB_EN
        input  op_sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/rca_seq_ctrl_nibble_adder.sv
// nibble_adder: combinational 4-bit ripple of full adders.
// Ports: a_i, b_i (4b), cin_i -> s_o (4b), cout_o.
module nibble_adder
    import rca_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] s_o,
    output logic             cout_o
);
    logic [NIB_W:0] c;

    assign c[0] = cin_i;
    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o = c[NIB_W];
endmodule

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: wide adder built from one 4-bit ripple adder, one nibble per clock, LSB first.
// Ports: clk, reset (async, active-high), bus (rca_seq_ctrl_if.slave: operands in, sum/cout out).
// Build option: SUB_EN adds op_sub; a-b is computed as a + ~b + 1 and cout=1 means no borrow.
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic          clk,
    input logic          reset,
    rca_seq_ctrl_if.slave bus
);
    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [NIB_W-1:0] nib_s;
    logic             nib_c;
    logic             sub;

`ifdef SUB_EN
    assign sub = bus.op_sub;
`else
    assign sub = 1'b0;
`endif

    nibble_adder u_add (
        .a_i   (a_q[NIB_W-1:0]),
        .b_i   (b_q[NIB_W-1:0]),
        .cin_i (carry_q),
        .s_o   (nib_s),
        .cout_o(nib_c)
    );

    // acc_q collects the sum while running; sum_q only changes on the final
    // nibble so the visible result holds until the next op completes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == ST_IDLE) begin
            if (bus.in_valid) begin
                state_d = ST_RUN;
                idx_d   = '0;
                a_d     = bus.a;
                b_d     = sub ? ~bus.b : bus.b;
                carry_d = sub | bus.cin;
            end
        end else if (state_q == ST_RUN) begin
            a_d     = a_q >> NIB_W;
            b_d     = b_q >> NIB_W;
            acc_d   = {nib_s, acc_q[W-1:NIB_W]};
            carry_d = nib_c;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(NIBBLES - 1)) begin
                state_d = ST_DONE;
                sum_d   = {nib_s, acc_q[W-1:NIB_W]};
                cout_d  = nib_c;
            end
        end else if (state_q == ST_DONE) begin
            state_d = bus.out_ready ? ST_IDLE : ST_DONE;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) & ~reset;
    assign bus.out_valid = state_q == ST_DONE;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: directed and random checks of rca_seq_ctrl (NIBBLES=4) against an arithmetic model.
module tb_rca_seq_ctrl;
    localparam int NIBBLES = 4;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_r;

    always #5 clk = ~clk;

    rca_seq_ctrl_if #(.NIBBLES(NIBBLES)) bus ();
    rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [16:0] model(input logic [15:0] a, b, input logic ci, sb);
        if (sb) return {a >= b, 16'(a - b)};
        return 17'(a) + 17'(b) + 17'(ci);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [15:0] a, b, input logic ci, sb);
        bus.a   = a;
        bus.b   = b;
        bus.cin = ci;
`ifdef SUB_EN
        bus.op_sub = sb;
`endif
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [15:0] a, b, input logic ci, sb);
        int n = 0;
        set_ops(a, b, ci, sb);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_r = model(a, b, ci, sb);
        chk("run_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    // Waits for the result, holds it for bp cycles with noise on in_valid,
    // then drains; with nxt set, a new op is offered on the draining cycle.
    task automatic finish_op(input int bp, input logic nxt, input logic [15:0] na, nb,
                             input logic nci, nsb);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!bus.out_valid && n < 20);
        chk("latency", 32'(n), 32'(NIBBLES));
        chk("sum", 32'(bus.sum), 32'(exp_r[15:0]));
        chk("cout", 32'(bus.cout), 32'(exp_r[16]));
        for (int i = 0; i < bp; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            set_ops(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_sum", {15'd0, bus.cout, bus.sum}, 32'(exp_r));
        end
        bus.in_valid = nxt;
        if (nxt) set_ops(na, nb, nci, nsb);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
        chk("drain_hold", {15'd0, bus.cout, bus.sum}, 32'(exp_r));
    endtask

    task automatic op(input logic [15:0] a, b, input logic ci, sb, input int bp);
        launch(a, b, ci, sb);
        finish_op(bp, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_ops(16'd0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", {15'd0, bus.cout, bus.sum}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        op(16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        launch(16'h1234, 16'h4321, 1'b1, 1'b0);
        finish_op(0, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
        launch(16'h8000, 16'h8000, 1'b0, 1'b0);
        finish_op(0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        op(16'hABCD, 16'h1111, 1'b0, 1'b0, 5);

        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum", {15'd0, bus.cout, bus.sum}, 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

        for (int k = 0; k < 20; k++)
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));

`ifdef SUB_EN
        op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        for (int k = 0; k < 10; k++)
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
